ps2_key_tracker: RTL

- Parametrised next-generation PS/2 keyboard front end. Receives PS/2 frames, decodes make/break/extended (E0) prefixes and tracks the held state of a configurable table of keys.
- Queues make/break events in a small ready/valid FIFO for the game controller.
- Sits between the PS/2 pins and the player-movement logic. Handles the E0-prefixed arrow keys and simultaneous key holds.

---
 rtl/ps2_key_tracker_if.sv | 8 +
 rtl/ps2_key_tracker.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: ready/valid key-event stream from the PS/2 tracker to its consumer
interface ps2_key_tracker_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_data;
  modport master (output ev_valid, ev_data, input ev_ready);
  modport slave (input ev_valid, ev_data, output ev_ready);
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 receiver, make/break/E0 decoder, held-key table and event FIFO
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity fails.
module ps2_key_tracker #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_KEYS = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_TABLE = {9'h175, 9'h172, 9'h174, 9'h16B}
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ps2c,
  input  logic                ps2d,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_held,
  output logic                frame_err,
  output logic                ev_overflow,
  input  logic                ovf_clr,
  ps2_key_tracker_if.master   ev
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic {RX_IDLE, RX_BITS} rx_t;
  typedef enum logic [1:0] {D_IDLE = 2'b00, D_E0 = 2'b01, D_F0 = 2'b10, D_E0F0 = 2'b11} dec_t;
  logic [1:0] c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic fc_q, fc_d, fe, din;
  rx_t rx_q, rx_d;
  dec_t dec_q, dec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic bv_q, bv_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic last, timeout, par_ok;
  logic [7:0] b;
  logic is_e0, is_f0, is_e1, emit;
  logic [9:0] ev_word;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW-1:0] head_idx;
  logic full, empty, push, pop;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q <= RX_IDLE;
      dec_q <= D_IDLE;
    end else begin
      rx_q <= rx_d;
      dec_q <= dec_d;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q <= '1;
      fc_q <= 1'b1;
      cnt_q <= '0;
      sh_q <= '0;
      wd_q <= '0;
      bv_q <= 1'b0;
      ferr_q <= 1'b0;
      held_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      filt_q <= filt_d;
      fc_q <= fc_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      wd_q <= wd_d;
      bv_q <= bv_d;
      ferr_q <= ferr_d;
      held_q <= held_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q[AW-1:0]] <= ev_word;
    end
  end
  // fc only moves once the whole window agrees, so short glitches on ps2c are ignored
  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
    fc_d = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : fc_q;
    fe = fc_q & ~fc_d;
    din = d_sync_q[1];
  end
  always_comb begin
    last = cnt_q == 4'd1;
    timeout = rx_q == RX_BITS && !fe && wd_q == WW'(TIMEOUT_CYC);
    rx_d = rx_q == RX_IDLE ? ((fe && !din) ? RX_BITS : RX_IDLE)
                           : ((timeout || (fe && last)) ? RX_IDLE : RX_BITS);
  end
  always_comb begin
    sh_d = (rx_q == RX_BITS && fe) ? {din, sh_q[9:1]} : sh_q;
`ifdef PS2_PARITY_CHECK_EN
    par_ok = ^sh_d[8:0];
`else
    par_ok = 1'b1;
`endif
    cnt_d = rx_q == RX_IDLE ? (fe ? 4'd10 : cnt_q) : (fe ? cnt_q - 4'd1 : cnt_q);
    wd_d = (rx_q == RX_IDLE || fe) ? '0 : wd_q + 1'b1;
    bv_d = rx_q == RX_BITS && fe && last && din && par_ok;
    ferr_d = (rx_q == RX_IDLE && fe && din) || (rx_q == RX_BITS && fe && last && !(din && par_ok)) || timeout;
  end
  // decoder state bits double as the {brk, ext} flags of the pending event
  always_comb begin
    b = sh_q[7:0];
    is_e0 = b == 8'hE0;
    is_f0 = b == 8'hF0;
    is_e1 = b == 8'hE1;
    dec_d = timeout ? D_IDLE : !bv_q ? dec_q : dec_q[1] ? D_IDLE :
            is_e0 ? D_E0 : is_f0 ? dec_t'({1'b1, dec_q[0]}) : D_IDLE;
  end
  always_comb begin
    emit = bv_q && !is_e0 && !is_f0 && !(dec_q == D_IDLE && is_e1);
    ev_word = {dec_q, b};
  end
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++)
      held_d[i] = (emit && KEY_TABLE[9*i +: 9] == ev_word[8:0]) ? ~ev_word[9] : held_q[i];
  end
  always_comb begin
    empty = wp_q == rp_q;
    full = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
    pop = !empty && ev.ev_ready;
    push = emit && (!full || pop);
    wp_d = wp_q + {{AW{1'b0}}, push};
    rp_d = rp_q + {{AW{1'b0}}, pop};
    ovf_d = (emit && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    head_idx = empty ? rp_q[AW-1:0] - AW'(1) : rp_q[AW-1:0];
  end
  assign ev.ev_valid = !empty;
  assign ev.ev_data = mem_q[head_idx];
  assign key_held = held_q;
  assign any_held = |held_q;
  assign frame_err = ferr_q;
  assign ev_overflow = ovf_q;
endmodule
